// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter between ICache fetches and LSB
// loads/stores in front of a byte-serial memory controller.
// Optional feature: define ARB_AGING_EN to add an ICache starvation guard
// (3-bit age counter compared against AGE_LIMIT); default build is fixed
// LSB-over-ICache priority.
module mem_arbiter #(
  parameter int unsigned AGE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        io_buffer_full,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [5:0]  lsb_op,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  output logic        mc_req,
  output logic        mc_wr,
  output logic [5:0]  mc_op,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  input  logic        mc_valid,
  input  logic [31:0] mc_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam logic [OP_W-1:0] OP_LW = OP_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IC  = 2'd1,
    ST_BUSY_LSB = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_drop;
  logic              w_drop_nxt;
  logic              w_lsb_blocked;
  logic              w_lsb_ok;
  logic              w_ic_ok;
  logic              w_ic_first;
  logic              w_grant_lsb;
  logic              w_grant_ic;
  logic              w_complete;
  logic              w_mc_req_nxt;
  logic              w_mc_wr_nxt;
  logic [OP_W-1:0]   w_mc_op_nxt;
  logic [DATA_W-1:0] w_mc_addr_nxt;
  logic [DATA_W-1:0] w_mc_wdata_nxt;
  logic              w_ic_done_nxt;
  logic [DATA_W-1:0] w_ic_data_nxt;
  logic              w_lsb_done_nxt;
  logic [DATA_W-1:0] w_lsb_rdata_nxt;

  // Stores into the UART window stall while its buffer is full
  assign w_lsb_blocked = lsb_wr & (lsb_addr[17:16] == 2'b11) & io_buffer_full;
  assign w_lsb_ok      = lsb_req & ~w_lsb_blocked;
  assign w_ic_ok       = ic_req & ~clear_in;

`ifdef ARB_AGING_EN
  localparam int unsigned AGE_W = 3;
  logic [AGE_W-1:0] r_age;

  assign w_ic_first = w_ic_ok & (r_age == AGE_W'(AGE_LIMIT));

  // Count LSB wins while ICache is kept waiting
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_age <= '0;
    end else if (rdy_in) begin
      if (!ic_req || w_grant_ic) begin
        r_age <= '0;
      end else if (w_grant_lsb && (r_age != {AGE_W{1'b1}})) begin
        r_age <= r_age + AGE_W'(1);
      end
    end
  end
`else
  logic w_unused_age;
  assign w_ic_first   = 1'b0;
  assign w_unused_age = (AGE_LIMIT != 0);
`endif

  assign w_grant_lsb = (r_state == ST_IDLE) & w_lsb_ok & ~w_ic_first;
  assign w_grant_ic  = (r_state == ST_IDLE) & w_ic_ok & (w_ic_first | ~w_lsb_ok);
  assign w_complete  = (r_state != ST_IDLE) & mc_valid;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: grant from IDLE, return on downstream completion
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_lsb) begin
          w_state_nxt = ST_BUSY_LSB;
        end else if (w_grant_ic) begin
          w_state_nxt = ST_BUSY_IC;
        end
      end
      ST_BUSY_IC, ST_BUSY_LSB: begin
        if (mc_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next output values: latch request on grant, return data on completion
  always_comb begin
    w_mc_req_nxt    = mc_req;
    w_mc_wr_nxt     = mc_wr;
    w_mc_op_nxt     = mc_op;
    w_mc_addr_nxt   = mc_addr;
    w_mc_wdata_nxt  = mc_wdata;
    w_ic_done_nxt   = 1'b0;
    w_ic_data_nxt   = ic_data;
    w_lsb_done_nxt  = 1'b0;
    w_lsb_rdata_nxt = lsb_rdata;
    w_drop_nxt      = r_drop;

    if (w_grant_lsb) begin
      w_mc_req_nxt   = 1'b1;
      w_mc_wr_nxt    = lsb_wr;
      w_mc_op_nxt    = lsb_op;
      w_mc_addr_nxt  = lsb_addr;
      w_mc_wdata_nxt = lsb_wdata;
    end else if (w_grant_ic) begin
      w_mc_req_nxt   = 1'b1;
      w_mc_wr_nxt    = 1'b0;
      w_mc_op_nxt    = OP_LW;
      w_mc_addr_nxt  = ic_addr;
      w_mc_wdata_nxt = '0;
    end

    if ((r_state == ST_BUSY_IC) && clear_in) begin
      w_drop_nxt = 1'b1;
    end

    if (w_complete) begin
      w_mc_req_nxt = 1'b0;
      w_drop_nxt   = 1'b0;
      if (r_state == ST_BUSY_IC) begin
        // A flush seen at any point of the fetch discards its result
        if (!(r_drop || clear_in)) begin
          w_ic_done_nxt = 1'b1;
          w_ic_data_nxt = mc_rdata;
        end
      end else begin
        w_lsb_done_nxt = 1'b1;
        if (!mc_wr) begin
          w_lsb_rdata_nxt = mc_rdata;
        end
      end
    end
  end

  // Output and drop-flag registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mc_req    <= 1'b0;
      mc_wr     <= 1'b0;
      mc_op     <= '0;
      mc_addr   <= '0;
      mc_wdata  <= '0;
      ic_done   <= 1'b0;
      ic_data   <= '0;
      lsb_done  <= 1'b0;
      lsb_rdata <= '0;
      r_drop    <= 1'b0;
    end else if (rdy_in) begin
      mc_req    <= w_mc_req_nxt;
      mc_wr     <= w_mc_wr_nxt;
      mc_op     <= w_mc_op_nxt;
      mc_addr   <= w_mc_addr_nxt;
      mc_wdata  <= w_mc_wdata_nxt;
      ic_done   <= w_ic_done_nxt;
      ic_data   <= w_ic_data_nxt;
      lsb_done  <= w_lsb_done_nxt;
      lsb_rdata <= w_lsb_rdata_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: single-transaction vector table plus
// hand-written multi-cycle sequences (priority, IO blocking, flush, rdy
// stall, reset abandon, aging).
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in, io_buffer_full;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_done;
  logic [31:0] ic_data;
  logic        lsb_req, lsb_wr;
  logic [5:0]  lsb_op;
  logic [31:0] lsb_addr, lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        mc_req, mc_wr;
  logic [5:0]  mc_op;
  logic [31:0] mc_addr, mc_wdata;
  logic        mc_valid;
  logic [31:0] mc_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .io_buffer_full(io_buffer_full),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_op(lsb_op), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mc_req(mc_req), .mc_wr(mc_wr), .mc_op(mc_op), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_valid(mc_valid), .mc_rdata(mc_rdata)
  );

  typedef struct {
    logic        is_lsb;
    logic        wr;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic        exp_wr;
    logic [5:0]  exp_op;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[5];
  logic exp_ic_grant[6];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One-cycle completion pulse from the memory controller
  task automatic complete(input logic [31:0] data);
    mc_valid = 1'b1;
    mc_rdata = data;
    tick();
    mc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // IC fetch, LSB load, UART-window store (buffer not full), IC fetch, IO load
    tbl[0] = '{1'b0, 1'b0, 6'd0,  32'h0000_1000, 32'h0,         32'h00A0_0093, 5, 1'b0, 6'd2,  32'h0,         32'h00A0_0093};
    tbl[1] = '{1'b1, 1'b0, 6'd5,  32'h0000_2000, 32'h1111_1111, 32'hDEAD_BEEF, 3, 1'b0, 6'd5,  32'h1111_1111, 32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 1'b1, 6'd8,  32'h0003_0000, 32'hCAFE_F00D, 32'h5555_5555, 1, 1'b1, 6'd8,  32'hCAFE_F00D, 32'hDEAD_BEEF};
    tbl[3] = '{1'b0, 1'b0, 6'd0,  32'h0000_1004, 32'h0,         32'h1234_5678, 2, 1'b0, 6'd2,  32'h0,         32'h1234_5678};
    tbl[4] = '{1'b1, 1'b0, 6'd5,  32'h0003_0004, 32'h0,         32'h0000_0041, 4, 1'b0, 6'd5,  32'h0,         32'h0000_0041};
`ifdef ARB_AGING_EN
    exp_ic_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_ic_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_op = '0; lsb_addr = '0; lsb_wdata = '0;
    mc_valid = 1'b0; mc_rdata = '0;
    tick(); tick();
    chk("rst_mc_req",    32'(mc_req),    32'h0);
    chk("rst_mc_wr",     32'(mc_wr),     32'h0);
    chk("rst_mc_op",     32'(mc_op),     32'h0);
    chk("rst_mc_addr",   mc_addr,        32'h0);
    chk("rst_mc_wdata",  mc_wdata,       32'h0);
    chk("rst_ic_done",   32'(ic_done),   32'h0);
    chk("rst_ic_data",   ic_data,        32'h0);
    chk("rst_lsb_done",  32'(lsb_done),  32'h0);
    chk("rst_lsb_rdata", lsb_rdata,      32'h0);
    rst_in = 1'b0;
    tick();

    // Single transactions from the table
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].is_lsb) begin
        lsb_req = 1'b1; lsb_wr = tbl[i].wr; lsb_op = tbl[i].op;
        lsb_addr = tbl[i].addr; lsb_wdata = tbl[i].wdata;
      end else begin
        ic_req = 1'b1; ic_addr = tbl[i].addr;
      end
      tick();
      ic_req = 1'b0; lsb_req = 1'b0;
      chk($sformatf("v%0d_mc_req", i),   32'(mc_req), 32'h1);
      chk($sformatf("v%0d_mc_addr", i),  mc_addr, tbl[i].addr);
      chk($sformatf("v%0d_mc_wr", i),    32'(mc_wr), 32'(tbl[i].exp_wr));
      chk($sformatf("v%0d_mc_op", i),    32'(mc_op), 32'(tbl[i].exp_op));
      chk($sformatf("v%0d_mc_wdata", i), mc_wdata, tbl[i].exp_wdata);
      for (int c = 1; c < tbl[i].lat; c++) tick();
      chk($sformatf("v%0d_hold_req", i), 32'(mc_req), 32'h1);
      complete(tbl[i].rdata);
      chk($sformatf("v%0d_req_drop", i), 32'(mc_req), 32'h0);
      if (tbl[i].is_lsb) begin
        chk($sformatf("v%0d_lsb_done", i), 32'(lsb_done), 32'h1);
        chk($sformatf("v%0d_ic_done", i),  32'(ic_done), 32'h0);
        chk($sformatf("v%0d_lsb_rdata", i), lsb_rdata, tbl[i].exp_data);
      end else begin
        chk($sformatf("v%0d_ic_done", i),  32'(ic_done), 32'h1);
        chk($sformatf("v%0d_lsb_done", i), 32'(lsb_done), 32'h0);
        chk($sformatf("v%0d_ic_data", i),  ic_data, tbl[i].exp_data);
      end
      tick();
      chk($sformatf("v%0d_done_pulse", i), 32'(ic_done | lsb_done), 32'h0);
    end

    // LSB wins a simultaneous request; ICache follows right after lsb_done
    ic_req = 1'b1; ic_addr = 32'h0000_1008;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_op = 6'd5; lsb_addr = 32'h0000_2000;
    tick();
    lsb_req = 1'b0;
    chk("prio_lsb_addr", mc_addr, 32'h0000_2000);
    tick();
    complete(32'hA5A5_A5A5);
    chk("prio_lsb_done", 32'(lsb_done), 32'h1);
    chk("prio_gap_req",  32'(mc_req), 32'h0);
    tick();
    ic_req = 1'b0;
    chk("prio_ic_req",  32'(mc_req), 32'h1);
    chk("prio_ic_addr", mc_addr, 32'h0000_1008);
    chk("prio_ic_op",   32'(mc_op), 32'h2);
    complete(32'h0000_0013);
    chk("prio_ic_done", 32'(ic_done), 32'h1);
    chk("prio_ic_data", ic_data, 32'h0000_0013);
    tick();

    // Blocked UART store lets ICache through, store follows once buffer drains
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_op = 6'd8; lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0000_0041;
    ic_req = 1'b1; ic_addr = 32'h0000_100C;
    tick();
    ic_req = 1'b0;
    chk("io_ic_addr", mc_addr, 32'h0000_100C);
    chk("io_ic_wr",   32'(mc_wr), 32'h0);
    tick();
    io_buffer_full = 1'b0;
    complete(32'h0000_0077);
    chk("io_ic_done", 32'(ic_done), 32'h1);
    tick();
    lsb_req = 1'b0;
    chk("io_st_req",   32'(mc_req), 32'h1);
    chk("io_st_wr",    32'(mc_wr), 32'h1);
    chk("io_st_addr",  mc_addr, 32'h0003_0000);
    chk("io_st_wdata", mc_wdata, 32'h0000_0041);
    complete(32'hFFFF_FFFF);
    chk("io_st_done",  32'(lsb_done), 32'h1);
    chk("io_st_rdata", lsb_rdata, 32'hA5A5_A5A5);
    tick();

    // Flush during a fetch drops its result; next fetch is normal
    ic_req = 1'b1; ic_addr = 32'h0000_1010;
    tick();
    ic_req = 1'b0;
    chk("flush_req", 32'(mc_req), 32'h1);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    tick();
    complete(32'hBAD0_BAD0);
    chk("flush_no_done", 32'(ic_done), 32'h0);
    chk("flush_data",    ic_data, 32'h0000_0077);
    chk("flush_req_low", 32'(mc_req), 32'h0);
    ic_req = 1'b1; ic_addr = 32'h0000_1014;
    tick();
    ic_req = 1'b0;
    chk("postflush_addr", mc_addr, 32'h0000_1014);
    complete(32'h0000_600D);
    chk("postflush_done", 32'(ic_done), 32'h1);
    chk("postflush_data", ic_data, 32'h0000_600D);
    tick();

    // Flush in IDLE suppresses the fetch grant for that cycle only
    ic_req = 1'b1; ic_addr = 32'h0000_1018; clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    chk("idleclr_no_grant", 32'(mc_req), 32'h0);
    tick();
    ic_req = 1'b0;
    chk("idleclr_grant", 32'(mc_req), 32'h1);
    complete(32'h0000_0099);
    chk("idleclr_done", 32'(ic_done), 32'h1);

    // rdy_in low freezes the done pulse
    rdy_in = 1'b0;
    tick(); tick();
    chk("rdy_hold_done", 32'(ic_done), 32'h1);
    rdy_in = 1'b1;
    tick();
    chk("rdy_done_clr", 32'(ic_done), 32'h0);

    // Stray mc_valid in IDLE is ignored
    complete(32'h1234_0000);
    chk("idle_valid_ic",  32'(ic_done), 32'h0);
    chk("idle_valid_lsb", 32'(lsb_done), 32'h0);
    chk("idle_valid_req", 32'(mc_req), 32'h0);

    // Reset during BUSY_LSB abandons the load, even with rdy_in low
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_op = 6'd5; lsb_addr = 32'h0000_2004;
    tick();
    lsb_req = 1'b0;
    chk("rstmid_req", 32'(mc_req), 32'h1);
    rst_in = 1'b1; rdy_in = 1'b0;
    tick();
    rst_in = 1'b0; rdy_in = 1'b1;
    chk("rstmid_mc_req",  32'(mc_req), 32'h0);
    chk("rstmid_mc_addr", mc_addr, 32'h0);
    chk("rstmid_mc_op",   32'(mc_op), 32'h0);
    chk("rstmid_lsb_done", 32'(lsb_done), 32'h0);
    chk("rstmid_lsb_rdata", lsb_rdata, 32'h0);
    chk("rstmid_ic_data", ic_data, 32'h0);
    complete(32'h0BAD_0BAD);
    chk("rstmid_late_done", 32'(lsb_done), 32'h0);

    // Both requesters held high: grant order shows aging behaviour
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_op = 6'd5; lsb_addr = 32'h0000_2000;
    ic_req = 1'b1; ic_addr = 32'h0000_1000;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk($sformatf("age%0d_req", g), 32'(mc_req), 32'h1);
      chk($sformatf("age%0d_addr", g), mc_addr,
          exp_ic_grant[g] ? 32'h0000_1000 : 32'h0000_2000);
      complete(32'h0000_0000);
    end
    lsb_req = 1'b0; ic_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
